alu_seq: RTL

Bit-serial arithmetic sequencer for the lab's small-word arithmetic datapath. Given one operation request over a start/done handshake, it runs the operands through a single shared one-bit add/subtract cell, LSB first, one bit per clock. Supported operations are ones-complement addition with end-around carry, twos-complement negation, and subtraction with borrow. It sits between the switch/register front end and the LED result display, replacing three parallel combinational units with one sequenced cell.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Bit-serial add/negate/subtract sequencer built around one shared 1-bit cell, LSB first.
// Optional: define ALU_SEQ_REVSUB_EN to make op 11 a reverse subtract (b-a) instead of pass-through.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_NEG = 2'b01, OP_SUB = 2'b10, OP_X = 2'b11} op_t;

   state_t           r_state;
   state_t           w_next;
   op_t              r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_flag;

   logic             w_x;
   logic             w_y;
   logic             w_sub;
   logic             w_s;
   logic             w_cout;
   logic             w_last;
   logic [WIDTH-1:0] w_acc_next;

   // Operand selection for the shared cell; FIX feeds the partial result back with y=0.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_x   = 1'b0;
      w_y   = 1'b0;
      w_sub = 1'b0;
      if (r_state == S_FIX) begin
         w_x = r_acc[0];
      end else begin
         case (r_op)
            OP_ADD: begin
               w_x = r_a[r_cnt];
               w_y = r_b[r_cnt];
            end
            OP_NEG: begin
               w_x = ~r_a[r_cnt];
            end
            OP_SUB: begin
               w_x   = r_a[r_cnt];
               w_y   = r_b[r_cnt];
               w_sub = 1'b1;
            end
            OP_X: begin
`ifdef ALU_SEQ_REVSUB_EN
               w_x   = r_b[r_cnt];
               w_y   = r_a[r_cnt];
               w_sub = 1'b1;
`endif
            end
            default: begin
               w_x = 1'b0;
            end
         endcase
      end
   end

   assign w_s        = w_x ^ w_y ^ r_carry;
   assign w_cout     = w_sub ? ((~w_x & w_y) | (~(w_x ^ w_y) & r_carry))
                             : ((w_x & w_y) | ((w_x ^ w_y) & r_carry));
   assign w_last     = (r_cnt == LAST);
   assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
`ifdef ALU_SEQ_REVSUB_EN
               w_next = S_RUN;
`else
               w_next = (op == OP_X) ? S_DONE : S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (w_last) w_next = (r_op == OP_ADD && w_cout) ? S_FIX : S_DONE;
         end
         S_FIX: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN) || (r_state == S_FIX);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_acc    <= '0;
         r_result <= '0;
         r_flag   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op_t'(op);
                  r_cnt   <= '0;
                  r_carry <= (op == OP_NEG);
                  r_acc   <= '0;
`ifndef ALU_SEQ_REVSUB_EN
                  if (op == OP_X) begin
                     r_result <= a;
                     r_flag   <= 1'b0;
                  end
`endif
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_next;
               r_carry <= w_cout;
               r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
               // An add with carry-out goes to FIX; that carry=1 doubles as FIX's carry-in.
               if (w_last && !(r_op == OP_ADD && w_cout)) begin
                  r_result <= w_acc_next;
                  r_flag   <= (r_op == OP_ADD) ? 1'b0 : w_cout;
               end
            end
            S_FIX: begin
               r_acc   <= w_acc_next;
               r_carry <= w_cout;
               r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_acc_next;
                  r_flag   <= 1'b1;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign result = r_result;
   assign flag   = r_flag;

endmodule
